// File: rtl/i2c_apb_bridge.sv
// i2c_apb_bridge: APB slave front-end for the I2C PHY FIFOs.
// Packs {opcode, CFG_VAL} words into the config FIFO, pushes bytes into the
// TX FIFO, pops bytes from the RX FIFO, and reports FIFO/overflow status.
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request
//   PRDATA/PREADY/PSLVERR         APB response (combinational from state)
//   cfg_fifo_*                    config FIFO push side
//   tx_fifo_*                     TX FIFO push side
//   rx_fifo_*                     RX FIFO pop side (data valid cycle after rd_en)
module i2c_apb_bridge #(
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned CONFIG_DATA_WIDTH = 40,
  parameter int unsigned PHY_FIFO_WIDTH    = 8,
  parameter int unsigned STALL_MAX         = 1024
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic [31:0]                  PWDATA,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic                         cfg_fifo_wr_en,
  output logic [CONFIG_DATA_WIDTH-1:0] cfg_fifo_wr_data,
  input  logic                         cfg_fifo_full,
  output logic                         tx_fifo_wr_en,
  output logic [PHY_FIFO_WIDTH-1:0]    tx_fifo_wr_data,
  input  logic                         tx_fifo_full,
  output logic                         rx_fifo_rd_en,
  input  logic [PHY_FIFO_WIDTH-1:0]    rx_fifo_rd_data,
  input  logic                         rx_fifo_empty
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] A_CFG_VAL = 3'd0;
  localparam logic [2:0] A_CFG_CMD = 3'd1;
  localparam logic [2:0] A_TXDATA  = 3'd2;
  localparam logic [2:0] A_RXDATA  = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH_WAIT,
    S_RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       cfg_val_q, cfg_val_d;
  logic              ovf_q, ovf_d;
  logic              push_cfg_q, push_cfg_d;

  logic              access;
  logic [2:0]        idx;
  logic              target_full;
  logic [CONFIG_DATA_WIDTH-1:0] cfg_word;
  logic              unused_addr_bits;

  assign access      = PSEL & PENABLE;
  assign idx         = PADDR[4:2];
  assign target_full = push_cfg_q ? cfg_fifo_full : tx_fifo_full;
  assign cfg_word    = CONFIG_DATA_WIDTH'({PWDATA[7:0], cfg_val_q});

  // Only PADDR[4:2] is decoded; the rest of the address aliases.
  assign unused_addr_bits = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

  // State and register file.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_val_q  <= '0;
      ovf_q      <= 1'b0;
      push_cfg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_val_q  <= cfg_val_d;
      ovf_q      <= ovf_d;
      push_cfg_q <= push_cfg_d;
    end
  end

  // Next-state and APB/FIFO outputs. Everything is held low while PRESETn is
  // asserted so an abort mid-transfer drops strobes immediately.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cfg_val_d        = cfg_val_q;
    ovf_d            = ovf_q;
    push_cfg_d       = push_cfg_q;
    PRDATA           = '0;
    PREADY           = 1'b0;
    PSLVERR          = 1'b0;
    cfg_fifo_wr_en   = 1'b0;
    cfg_fifo_wr_data = '0;
    tx_fifo_wr_en    = 1'b0;
    tx_fifo_wr_data  = '0;
    rx_fifo_rd_en    = 1'b0;

    if (PRESETn) begin
      unique case (state_q)
        S_IDLE: begin
          if (access) begin
            unique case (idx)
              A_CFG_VAL: begin
                PREADY = 1'b1;
                if (PWRITE) cfg_val_d = PWDATA;
                else        PRDATA    = cfg_val_q;
              end
              A_CFG_CMD: begin
                if (PWRITE && cfg_fifo_full) begin
                  // First access cycle counts as wait state 1.
                  state_d    = S_PUSH_WAIT;
                  cnt_d      = CNT_W'(1);
                  push_cfg_d = 1'b1;
                end else begin
                  PREADY = 1'b1;
                  if (PWRITE) begin
                    cfg_fifo_wr_en   = 1'b1;
                    cfg_fifo_wr_data = cfg_word;
                  end
                end
              end
              A_TXDATA: begin
                if (PWRITE && tx_fifo_full) begin
                  state_d    = S_PUSH_WAIT;
                  cnt_d      = CNT_W'(1);
                  push_cfg_d = 1'b0;
                end else begin
                  PREADY = 1'b1;
                  if (PWRITE) begin
                    tx_fifo_wr_en   = 1'b1;
                    tx_fifo_wr_data = PWDATA[PHY_FIFO_WIDTH-1:0];
                  end
                end
              end
              A_RXDATA: begin
                if (!PWRITE && !rx_fifo_empty) begin
                  // Pop now; byte arrives next cycle and completes the read.
                  rx_fifo_rd_en = 1'b1;
                  state_d       = S_RD_WAIT;
                end else begin
                  PREADY = 1'b1;
                end
              end
              A_STATUS: begin
                PREADY = 1'b1;
                if (PWRITE) begin
                  if (PWDATA[3]) ovf_d = 1'b0;
                end else begin
                  PRDATA = {28'd0, ovf_q, rx_fifo_empty, tx_fifo_full, cfg_fifo_full};
                end
              end
              default: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
              end
            endcase
          end
        end

        S_PUSH_WAIT: begin
          if (!access) begin
            // Master abandoned the transfer: drop the push.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (!target_full) begin
            PREADY  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            if (push_cfg_q) begin
              cfg_fifo_wr_en   = 1'b1;
              cfg_fifo_wr_data = cfg_word;
            end else begin
              tx_fifo_wr_en   = 1'b1;
              tx_fifo_wr_data = PWDATA[PHY_FIFO_WIDTH-1:0];
            end
          end else if (cnt_q == CNT_W'(STALL_MAX)) begin
            // Stall budget exhausted: fail the transfer and flag overflow.
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            ovf_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RD_WAIT: begin
          state_d = S_IDLE;
          if (access) begin
            PREADY = 1'b1;
            PRDATA = 32'({1'b1, rx_fifo_rd_data});
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_bridge.sv
// Directed self-checking bench for i2c_apb_bridge (STALL_MAX = 8).
module tb_i2c_apb_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        cfg_fifo_wr_en;
  logic [39:0] cfg_fifo_wr_data;
  logic        cfg_fifo_full;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_wr_data;
  logic        tx_fifo_full;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_rd_data;
  logic        rx_fifo_empty;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  i2c_apb_bridge #(
    .ADDR_WIDTH(8), .CONFIG_DATA_WIDTH(40), .PHY_FIFO_WIDTH(8), .STALL_MAX(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_fifo_wr_en(cfg_fifo_wr_en), .cfg_fifo_wr_data(cfg_fifo_wr_data),
    .cfg_fifo_full(cfg_fifo_full),
    .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
    .tx_fifo_full(tx_fifo_full),
    .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_rd_data(rx_fifo_rd_data),
    .rx_fifo_empty(rx_fifo_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; release_at >= 0 drops tx_fifo_full after that many wait states.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                     input int release_at,
                     output logic [31:0] rdata, output logic err, output int waits,
                     output int cfg_n, output int tx_n, output int rd_n,
                     output logic [39:0] cfg_d, output logic [7:0] tx_d);
    bit done;
    waits = 0; cfg_n = 0; tx_n = 0; rd_n = 0;
    cfg_d = '0; tx_d = '0; rdata = '0; err = 1'b0; done = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    while (!done) begin
      @(negedge PCLK);
      if (cfg_fifo_wr_en) begin cfg_n++; cfg_d = cfg_fifo_wr_data; end
      if (tx_fifo_wr_en)  begin tx_n++;  tx_d  = tx_fifo_wr_data;  end
      if (rx_fifo_rd_en)  rd_n++;
      if (PREADY) begin
        done  = 1'b1;
        rdata = PRDATA;
        err   = PSLVERR;
      end else begin
        waits++;
        if (waits == release_at) tx_fifo_full = 1'b0;
        if (waits > 64) begin
          checks++;
          errors++;
          $error("FAIL apb_timeout observed=no_PREADY expected=PREADY within 64 cycles");
          done = 1'b1;
        end
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w, nc, nt, nr;
  logic [39:0] cd;
  logic [7:0]  td;

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    cfg_fifo_full = 1'b0; tx_fifo_full = 1'b0;
    rx_fifo_empty = 1'b1; rx_fifo_rd_data = 8'h3C;

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_ctrl", 64'({PREADY, PSLVERR, cfg_fifo_wr_en, tx_fifo_wr_en, rx_fifo_rd_en}), 64'd0);
    check("reset_prdata", 64'(PRDATA), 64'd0);
    check("reset_wrdata", 64'({cfg_fifo_wr_data, tx_fifo_wr_data}), 64'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    apb(1'b0, 8'h10, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("status_after_reset", 64'(rd), 64'h4);
    check("status_zero_wait", 64'(w), 64'd0);

    // Config pack
    apb(1'b1, 8'h00, 32'h0000_007C, -1, rd, er, w, nc, nt, nr, cd, td);
    apb(1'b1, 8'h04, 32'h0000_0000, -1, rd, er, w, nc, nt, nr, cd, td);
    check("cfg_push_count", 64'(nc), 64'd1);
    check("cfg_push_data", 64'(cd), 64'h00_0000_007C);
    check("cfg_push_waits", 64'(w), 64'd0);
    check("cfg_push_err", 64'(er), 64'd0);
    apb(1'b0, 8'h00, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("cfg_val_readback", 64'(rd), 64'h7C);

    apb(1'b1, 8'h00, 32'hDEAD_BEEF, -1, rd, er, w, nc, nt, nr, cd, td);
    apb(1'b1, 8'h04, 32'hFFFF_FF01, -1, rd, er, w, nc, nt, nr, cd, td);
    check("cfg_push_data2", 64'(cd), 64'h01_DEAD_BEEF);
    apb(1'b0, 8'h04, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("cfg_cmd_read", 64'({rd, 31'(nc), er}), 64'd0);

    // TX zero-wait push
    apb(1'b1, 8'h08, 32'h0000_005A, -1, rd, er, w, nc, nt, nr, cd, td);
    check("tx_fast_count", 64'(nt), 64'd1);
    check("tx_fast_data", 64'(td), 64'h5A);
    check("tx_fast_waits", 64'(w), 64'd0);

    // TX stall recovery after 5 wait states
    tx_fifo_full = 1'b1;
    apb(1'b1, 8'h08, 32'h0000_00A5, 5, rd, er, w, nc, nt, nr, cd, td);
    check("tx_stall_waits", 64'(w), 64'd5);
    check("tx_stall_count", 64'(nt), 64'd1);
    check("tx_stall_data", 64'(td), 64'hA5);
    check("tx_stall_err", 64'(er), 64'd0);

    // TX timeout with full held
    tx_fifo_full = 1'b1;
    apb(1'b1, 8'h08, 32'h0000_0077, -1, rd, er, w, nc, nt, nr, cd, td);
    check("tx_to_waits", 64'(w), 64'd8);
    check("tx_to_err", 64'(er), 64'd1);
    check("tx_to_count", 64'(nt), 64'd0);
    tx_fifo_full = 1'b0;
    apb(1'b0, 8'h10, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("status_ovf_set", 64'(rd), 64'hC);
    apb(1'b1, 8'h10, 32'h8, -1, rd, er, w, nc, nt, nr, cd, td);
    apb(1'b0, 8'h10, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("status_ovf_clr", 64'(rd), 64'h4);

    // RX with data
    rx_fifo_empty = 1'b0;
    apb(1'b0, 8'h0C, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("rx_data", 64'(rd), 64'h13C);
    check("rx_waits", 64'(w), 64'd1);
    check("rx_pops", 64'(nr), 64'd1);
    // RX empty
    rx_fifo_empty = 1'b1;
    apb(1'b0, 8'h0C, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("rx_empty_data", 64'(rd), 64'd0);
    check("rx_empty_waits_pops", 64'({32'(w), 32'(nr)}), 64'd0);

    // Bad address
    apb(1'b0, 8'h14, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("bad_rd_err", 64'(er), 64'd1);
    check("bad_rd_data", 64'(rd), 64'd0);
    check("bad_rd_strobes", 64'({16'(nc), 16'(nt), 16'(nr), 16'(w)}), 64'd0);
    apb(1'b1, 8'h14, 32'hFFFF_FFFF, -1, rd, er, w, nc, nt, nr, cd, td);
    check("bad_wr_err", 64'(er), 64'd1);
    check("bad_wr_strobes", 64'({16'(nc), 16'(nt), 16'(nr), 16'(w)}), 64'd0);

    // Reset during a stalled push: strobes must stay low immediately
    tx_fifo_full = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h11;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(negedge PCLK);
    tx_fifo_full = 1'b0;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_strobes", 64'({PREADY, PSLVERR, tx_fifo_wr_en, cfg_fifo_wr_en, rx_fifo_rd_en}), 64'd0);
    @(posedge PCLK); #1;
    check("rst_mid_hold", 64'({PREADY, tx_fifo_wr_en}), 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb(1'b0, 8'h00, 32'h0, -1, rd, er, w, nc, nt, nr, cd, td);
    check("rst_cfg_val", 64'(rd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_apb_bridge.md
# i2c_apb_bridge

APB slave front-end that feeds the I2C physical-layer stage. It packs 40-bit configuration words for the config FIFO and pushes command/data bytes into the write FIFO. It pops received bytes from the read FIFO, and the PeriPlex APB interconnect reaches all three FIFOs only through this block. It is the directly-upstream producer and downstream consumer of the I2C PHY FIFOs.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width; the block decodes only PADDR[4:2].
- CONFIG_DATA_WIDTH, 40, config FIFO word width; fixed layout {opcode[7:0], value[31:0]}.
- PHY_FIFO_WIDTH, 8, width of the TX and RX FIFO data.
- STALL_MAX, 1024, maximum wait states a push may stall on a full FIFO; legal range 1..65535.

Ports:
- PCLK  in  1  single clock for the block and all FIFO ports.
- PRESETn  in  1  reset, asynchronous and active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control signals.
- PADDR  in  ADDR_WIDTH  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data; 0 when not in a completing read.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error; valid only when PREADY=1.
- cfg_fifo_wr_en  out  1  config FIFO push strobe.
- cfg_fifo_wr_data  out  CONFIG_DATA_WIDTH  config word.
- cfg_fifo_full  in  1  config FIFO full flag.
- tx_fifo_wr_en  out  1  write FIFO push strobe.
- tx_fifo_wr_data  out  PHY_FIFO_WIDTH  command/data byte.
- tx_fifo_full  in  1  write FIFO full flag.
- rx_fifo_rd_en  out  1  read FIFO pop strobe.
- rx_fifo_rd_data  in  PHY_FIFO_WIDTH  read FIFO data; valid the cycle after rd_en.
- rx_fifo_empty  in  1  read FIFO empty flag.

## Operation
Register map (offsets):
- 0x00 CFG_VAL: RW. Holds the 32-bit staging value. Reset value is 0.
- 0x04 CFG_CMD: WO.
  - Pushes {PWDATA[7:0], CFG_VAL} to the config FIFO.
  - Opcode 0x00 sets the clock divider; opcode 0x01 with value bit0 set requests a PHY reset.
  - CFG_VAL is unchanged by the push.
  - A read returns 0.
- 0x08 TXDATA: WO. Pushes PWDATA[7:0] to the write FIFO. A read returns 0.
- 0x0C RXDATA: RO.
  - If the read FIFO is not empty, pops one byte and returns {23'b0, 1'b1, byte}.
  - If empty, returns 0 and does not pop.
  - A write is ignored and completes with OKAY.
- 0x10 STATUS:
  - Read returns {28'b0, ovf, rx_empty, tx_full, cfg_full}.
  - Writing 1 to bit3 clears ovf.
- Any other offset: access completes with no wait state, PSLVERR=1 and PRDATA=0.

FSM states:
- IDLE
  - Setup phase: no action.
  - Access phase: see the timing rules below.
- PUSH_WAIT
  - Entered when a push targets a full FIFO.
  - Stall counter (16 bit) increments every cycle.
  - If full deasserts: push in that cycle, PREADY=1, return to IDLE.
  - If the counter reaches STALL_MAX and the FIFO is still full: PREADY=1, PSLVERR=1, set ovf, drop the byte/word, return to IDLE.
- RD_WAIT: one cycle. PRDATA is driven from rx_fifo_rd_data, PREADY=1, return to IDLE.
- If PSEL deasserts in PUSH_WAIT or RD_WAIT (protocol violation): return to IDLE with no push; a byte already popped is lost.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; CFG_VAL=0, ovf=0, stall counter=0.
  - Asynchronous assertion, synchronous deassertion, taken at the next PCLK edge.
- Zero-wait accesses (PREADY=1 in the first access cycle): CFG_VAL, STATUS, unmapped offsets, RXDATA when empty, and pushes when the target FIFO is not full.
- Push strobes:
  - wr_en is high for exactly one cycle, the same cycle that PREADY=1 completes the access.
  - Write data is valid in that cycle.
  - At most one push per APB transfer.
- RXDATA pop:
  - Access cycle 1: rx_fifo_rd_en=1, PREADY=0.
  - Access cycle 2: PREADY=1 with the captured byte.
  - Latency is exactly one wait state.
- Stall limit: a full FIFO yields at most STALL_MAX wait states; PREADY rises on wait state STALL_MAX.
- STATUS reflects flag values sampled in the access cycle.
- Simultaneous ovf set (timeout) and clear (STATUS write) cannot occur, because transfers are serialized.
- Reset mid-operation (PUSH_WAIT/RD_WAIT): abort, all strobes low immediately, return to IDLE.

## Test plan
- Reset: PRESETn low → all outputs 0; read STATUS after release → 0x4 with rx_empty=1 and other flags 0.
- Config pack: write CFG_VAL=0x0000007C, then CFG_CMD=0x00 → one cfg_fifo_wr_en pulse with data 0x000000007C and no wait states; CFG_VAL reads back 0x7C.
- TX stall recovery: hold tx_fifo_full=1, write TXDATA=0xA5, release full after 5 cycles → 5 wait states, a single push of 0xA5, PSLVERR=0.
- TX timeout: STALL_MAX=8, full held high → PREADY after 8 wait states with PSLVERR=1, no push; STATUS bit3=1; write STATUS=0x8 → bit3=0.
- RX: FIFO holding 0x3C → RXDATA read returns 0x13C with exactly one wait state and one rd_en pulse; empty FIFO → returns 0, no rd_en.
- Bad address 0x14 read/write → PSLVERR=1, PRDATA=0, no FIFO strobes.
